ldst_ctrl: RTL and testbench

- Sequencing controller for the load-store address path.
- Accepts load/store uops from issue into an in-order queue and computes each effective address as the 32-bit sum opd1 + opd2.
- Drives one outstanding data-memory transaction at a time over a valid/ready request channel, then formats load data.
- Returns one writeback per uop, tagged with its ROB tag.

---
 rtl/ldst_ctrl_if.sv | 44 ++++
 rtl/ldst_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_ldst_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ldst_ctrl_if.sv
// Issue, data-memory and writeback signals of the load-store controller.
// The slave modport is the controller's view; the master modport is the environment's view.
`timescale 1ns/1ps
interface ldst_ctrl_if #(
    parameter int TAG_WIDTH = 6
);
    logic                 flush;
    logic                 in_valid;
    logic                 in_ready;
    logic                 in_is_store;
    logic [2:0]           in_funct3;
    logic [31:0]          in_opd1;
    logic [31:0]          in_opd2;
    logic [31:0]          in_store_data;
    logic [TAG_WIDTH-1:0] in_tag;

    logic                 mem_req_valid;
    logic                 mem_req_ready;
    logic                 mem_req_we;
    logic [31:0]          mem_req_addr;
    logic [31:0]          mem_req_wdata;
    logic [3:0]           mem_req_wstrb;
    logic                 mem_resp_valid;
    logic [31:0]          mem_resp_rdata;

    logic                 wb_valid;
    logic [TAG_WIDTH-1:0] wb_tag;
    logic [31:0]          wb_data;
    logic                 wb_exc;

    modport slave (
        input  flush, in_valid, in_is_store, in_funct3, in_opd1, in_opd2,
               in_store_data, in_tag, mem_req_ready, mem_resp_valid, mem_resp_rdata,
        output in_ready, mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
               mem_req_wstrb, wb_valid, wb_tag, wb_data, wb_exc
    );

    modport master (
        output flush, in_valid, in_is_store, in_funct3, in_opd1, in_opd2,
               in_store_data, in_tag, mem_req_ready, mem_resp_valid, mem_resp_rdata,
        input  in_ready, mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
               mem_req_wstrb, wb_valid, wb_tag, wb_data, wb_exc
    );
endinterface

// File: rtl/ldst_ctrl.sv
// Load-store sequencing controller: in-order uop queue, one outstanding memory
// transaction at a time, byte-lane formatting of store data and load results.
`timescale 1ns/1ps
module ldst_ctrl #(
    parameter int QUEUE_DEPTH = 4,
    parameter int TAG_WIDTH   = 6
) (
    input  logic       clk,
    input  logic       rst,
    ldst_ctrl_if.slave bus
);
    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(QUEUE_DEPTH);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CHECK = 3'd1;
    localparam logic [2:0] S_REQ   = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_WB    = 3'd4;
    localparam logic [2:0] S_DRAIN = 3'd5;

    logic                 r_q_we     [QUEUE_DEPTH];
    logic [2:0]           r_q_funct3 [QUEUE_DEPTH];
    logic [31:0]          r_q_ea     [QUEUE_DEPTH];
    logic [31:0]          r_q_sdata  [QUEUE_DEPTH];
    logic [TAG_WIDTH-1:0] r_q_tag    [QUEUE_DEPTH];

    logic [PTR_W-1:0]     r_wptr;
    logic [PTR_W-1:0]     r_rptr;
    logic [PTR_W:0]       r_count;
    logic [2:0]           r_state;
    logic [31:0]          r_wb_data;
    logic                 r_wb_exc;

    logic                 w_enq;
    logic                 w_pop;
    logic                 w_empty;
    logic                 w_h_we;
    logic [2:0]           w_h_funct3;
    logic [31:0]          w_h_ea;
    logic [31:0]          w_h_sdata;
    logic [TAG_WIDTH-1:0] w_h_tag;
    logic                 w_exc;
    logic [3:0]           w_wstrb;
    logic [31:0]          w_wdata;
    logic                 w_in_req;
    logic                 w_wb;

    // Select the addressed byte/half from the read word and extend it to 32 bits.
    function automatic logic [31:0] load_extend(input logic [31:0] rdata,
                                                input logic [2:0]  funct3,
                                                input logic [1:0]  off);
        logic [31:0]        sh;
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic signed [31:0] ext;
        sh  = rdata >> {off, 3'b000};
        b   = sh[7:0];
        h   = sh[15:0];
        ext = '0;
        case (funct3)
            3'b000:  ext = b;
            3'b001:  ext = h;
            3'b100:  ext = {24'h0, sh[7:0]};
            3'b101:  ext = {16'h0, sh[15:0]};
            default: ext = sh;
        endcase
        return $unsigned(ext);
    endfunction

    assign w_empty       = (r_count == '0);
    assign bus.in_ready  = (r_count < DEPTH_C);
    assign w_enq         = bus.in_valid && bus.in_ready && !bus.flush;
    assign w_pop         = (r_state == S_WB);

    assign w_h_we        = r_q_we[r_rptr];
    assign w_h_funct3    = r_q_funct3[r_rptr];
    assign w_h_ea        = r_q_ea[r_rptr];
    assign w_h_sdata     = r_q_sdata[r_rptr];
    assign w_h_tag       = r_q_tag[r_rptr];

    // Queue payload; the effective address is formed once, at enqueue.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_q_we[r_wptr]     <= bus.in_is_store;
            r_q_funct3[r_wptr] <= bus.in_funct3;
            r_q_ea[r_wptr]     <= bus.in_opd1 + bus.in_opd2;
            r_q_sdata[r_wptr]  <= bus.in_store_data;
            r_q_tag[r_wptr]    <= bus.in_tag;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (bus.flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq) r_wptr <= r_wptr + 1'b1;
            if (w_pop) r_rptr <= r_rptr + 1'b1;
            case ({w_enq, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_comb begin
        w_exc = 1'b0;
        case (w_h_funct3)
            3'b001, 3'b101:         w_exc = w_h_ea[0];
            3'b010:                 w_exc = |w_h_ea[1:0];
            3'b011, 3'b110, 3'b111: w_exc = 1'b1;
            default:                w_exc = 1'b0;
        endcase
    end

    always_comb begin
        w_wstrb = 4'b1111;
        case (w_h_funct3[1:0])
            2'b00:   w_wstrb = 4'b0001 << w_h_ea[1:0];
            2'b01:   w_wstrb = 4'b0011 << w_h_ea[1:0];
            default: w_wstrb = 4'b1111;
        endcase
    end

    assign w_wdata = w_h_sdata << {w_h_ea[1:0], 3'b000};

    // A handshake taken in the flush cycle still counts: stores are done, loads must drain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (!bus.flush && !w_empty) r_state <= S_CHECK;
                S_CHECK: begin
                    if (bus.flush)  r_state <= S_IDLE;
                    else if (w_exc) r_state <= S_WB;
                    else            r_state <= S_REQ;
                end
                S_REQ: begin
                    if (bus.mem_req_ready) begin
                        if (w_h_we) r_state <= bus.flush ? S_IDLE : S_WB;
                        else        r_state <= bus.flush ? S_DRAIN : S_WAIT;
                    end else if (bus.flush) begin
                        r_state <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (bus.flush)               r_state <= bus.mem_resp_valid ? S_IDLE : S_DRAIN;
                    else if (bus.mem_resp_valid) r_state <= S_WB;
                end
                S_WB:    r_state <= S_IDLE;
                S_DRAIN: if (bus.mem_resp_valid) r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        case (r_state)
            S_CHECK: begin
                r_wb_data <= '0;
                r_wb_exc  <= w_exc;
            end
            S_WAIT: begin
                if (bus.mem_resp_valid)
                    r_wb_data <= load_extend(bus.mem_resp_rdata, w_h_funct3, w_h_ea[1:0]);
            end
            default: begin
                r_wb_data <= r_wb_data;
                r_wb_exc  <= r_wb_exc;
            end
        endcase
    end

    assign w_in_req          = (r_state == S_REQ);
    assign bus.mem_req_valid = w_in_req;
    assign bus.mem_req_we    = w_in_req && w_h_we;
    assign bus.mem_req_addr  = w_in_req ? {w_h_ea[31:2], 2'b00} : 32'h0;
    assign bus.mem_req_wdata = (w_in_req && w_h_we) ? w_wdata : 32'h0;
    assign bus.mem_req_wstrb = (w_in_req && w_h_we) ? w_wstrb : 4'b0000;

    assign w_wb              = (r_state == S_WB) && !bus.flush;
    assign bus.wb_valid      = w_wb;
    assign bus.wb_tag        = w_wb ? w_h_tag : '0;
    assign bus.wb_data       = w_wb ? r_wb_data : 32'h0;
    assign bus.wb_exc        = w_wb && r_wb_exc;
endmodule

// File: tb/tb_ldst_ctrl.sv
// Directed bench for ldst_ctrl: vector table of single uops plus stall, ordering,
// queue-full, flush and reset sequences.
`timescale 1ns/1ps
module tb_ldst_ctrl;
    localparam int TW = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ldst_ctrl_if #(.TAG_WIDTH(TW)) bus ();
    ldst_ctrl #(.QUEUE_DEPTH(4), .TAG_WIDTH(TW)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic          st;
        logic [2:0]    f3;
        logic [31:0]   o1;
        logic [31:0]   o2;
        logic [31:0]   sd;
        logic [TW-1:0] tag;
        logic [31:0]   rdata;
        logic [31:0]   e_addr;
        logic [3:0]    e_strb;
        logic [31:0]   e_wdata;
        logic [31:0]   e_wb;
        logic          e_exc;
        int            e_lat;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs [NV];
    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic st, input logic [2:0] f3, input logic [31:0] o1,
                         input logic [31:0] o2, input logic [31:0] sd, input logic [TW-1:0] tag);
        bus.in_is_store   = st;
        bus.in_funct3     = f3;
        bus.in_opd1       = o1;
        bus.in_opd2       = o2;
        bus.in_store_data = sd;
        bus.in_tag        = tag;
    endtask

    task automatic run_vec(input int i);
        vec_t v = vecs[i];
        bit seen_req = 0;
        bit seen_wb  = 0;
        bit pend     = 0;
        @(negedge clk);
        drive(v.st, v.f3, v.o1, v.o2, v.sd, v.tag);
        bus.mem_req_ready = 1'b1;
        bus.in_valid      = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        for (int k = 0; k < 12 && !seen_wb; k++) begin
            bus.mem_resp_valid = pend;
            bus.mem_resp_rdata = pend ? v.rdata : 32'h0;
            pend = 0;
            if (bus.mem_req_valid && !seen_req) begin
                seen_req = 1;
                chk($sformatf("v%0d addr", i), bus.mem_req_addr, v.e_addr);
                chk($sformatf("v%0d we", i), bus.mem_req_we, v.st);
                chk($sformatf("v%0d wstrb", i), bus.mem_req_wstrb, v.e_strb);
                chk($sformatf("v%0d wdata", i), bus.mem_req_wdata, v.e_wdata);
                pend = !v.st;
            end
            if (bus.wb_valid) begin
                seen_wb = 1;
                chk($sformatf("v%0d latency", i), k, v.e_lat);
                chk($sformatf("v%0d wb_tag", i), bus.wb_tag, v.tag);
                chk($sformatf("v%0d wb_data", i), bus.wb_data, v.e_wb);
                chk($sformatf("v%0d wb_exc", i), bus.wb_exc, v.e_exc);
            end
            @(negedge clk);
        end
        bus.mem_resp_valid = 1'b0;
        chk($sformatf("v%0d wb seen", i), seen_wb, 1);
        chk($sformatf("v%0d request issued", i), seen_req, !v.e_exc);
    endtask

    task automatic seq_store_stall();
        bit got = 0;
        @(negedge clk);
        drive(1'b1, 3'b001, 32'h3000, 32'h2, 32'h1234ABCD, 6'd21);
        bus.mem_req_ready = 1'b0;
        bus.in_valid      = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        for (int t = 0; t < 10 && !got; t++) begin
            if (bus.mem_req_valid) got = 1;
            else @(negedge clk);
        end
        chk("sh request seen", got, 1);
        for (int s = 0; s < 4; s++) begin
            chk("sh stall valid", bus.mem_req_valid, 1);
            chk("sh stall addr", bus.mem_req_addr, 32'h3000);
            chk("sh stall wstrb", bus.mem_req_wstrb, 4'b1100);
            chk("sh stall wdata hi", bus.mem_req_wdata[31:16], 16'hABCD);
            chk("sh stall we", bus.mem_req_we, 1);
            chk("sh stall no wb", bus.wb_valid, 0);
            if (s == 3) bus.mem_req_ready = 1'b1;
            @(negedge clk);
        end
        chk("sh wb valid", bus.wb_valid, 1);
        chk("sh wb tag", bus.wb_tag, 6'd21);
        chk("sh wb data", bus.wb_data, 32'h0);
        chk("sh wb exc", bus.wb_exc, 0);
        chk("sh req dropped", bus.mem_req_valid, 0);
        @(negedge clk);
        chk("sh wb one cycle", bus.wb_valid, 0);
    endtask

    task automatic seq_exceptions();
        int wbn  = 0;
        int reqs = 0;
        @(negedge clk);
        drive(1'b0, 3'b010, 32'h4000, 32'h2, 32'h0, 6'd10);
        bus.in_valid = 1'b1;
        @(negedge clk);
        drive(1'b0, 3'b011, 32'h4000, 32'h0, 32'h0, 6'd11);
        @(negedge clk);
        bus.in_valid = 1'b0;
        for (int t = 0; t < 15; t++) begin
            if (bus.mem_req_valid) reqs++;
            if (bus.wb_valid) begin
                chk("exc wb tag order", bus.wb_tag, 10 + wbn);
                chk("exc wb flag", bus.wb_exc, 1);
                chk("exc wb data", bus.wb_data, 32'h0);
                wbn++;
            end
            @(negedge clk);
        end
        chk("exc no mem request", reqs, 0);
        chk("exc wb count", wbn, 2);
    endtask

    task automatic seq_queue_full();
        int idx = 0;
        int wbn = 0;
        bus.mem_req_ready = 1'b0;
        for (int t = 0; t < 60 && wbn < 5; t++) begin
            if (bus.wb_valid) begin
                chk("full wb tag order", bus.wb_tag, 40 + wbn);
                wbn++;
            end
            if (t == 10) begin
                chk("full in_ready low", bus.in_ready, 0);
                chk("full accepted four", idx, 4);
                bus.mem_req_ready = 1'b1;
            end
            if (idx < 5) begin
                drive(1'b1, 3'b010, 32'hB000 + 32'(4 * idx), 32'h0, 32'h100 + 32'(idx), 6'(40 + idx));
                bus.in_valid = 1'b1;
                if (bus.in_ready) begin
                    if (idx == 4) chk("full 5th after first wb", wbn >= 1, 1);
                    idx++;
                end
            end else begin
                bus.in_valid = 1'b0;
            end
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        chk("full wb count", wbn, 5);
        chk("full accepted all", idx, 5);
    endtask

    task automatic seq_flush_wait();
        int wbn  = 0;
        bit seen = 0;
        bit pend = 0;
        bus.mem_req_ready = 1'b1;
        for (int t = 0; t < 22; t++) begin
            if (t >= 7) begin
                bus.mem_resp_valid = pend;
                bus.mem_resp_rdata = pend ? 32'h600DF00D : 32'h0;
                pend = 0;
            end
            case (t)
                0: begin drive(1'b0, 3'b010, 32'h9000, 32'h0, 32'h0, 6'd30); bus.in_valid = 1'b1; end
                1: bus.in_valid = 1'b0;
                4: begin chk("flush in wait no req", bus.mem_req_valid, 0); bus.flush = 1'b1; end
                5: begin
                    bus.flush = 1'b0;
                    chk("flush in_ready", bus.in_ready, 1);
                    drive(1'b0, 3'b010, 32'hA000, 32'h0, 32'h0, 6'd31);
                    bus.in_valid = 1'b1;
                end
                6: begin bus.in_valid = 1'b0; bus.mem_resp_valid = 1'b1; bus.mem_resp_rdata = 32'hBADBAD00; end
                default: ;
            endcase
            if (t >= 7 && bus.mem_req_valid && !seen) begin
                seen = 1;
                chk("flush new req addr", bus.mem_req_addr, 32'hA000);
                pend = 1;
            end
            if (bus.wb_valid) begin
                chk("flush wb tag", bus.wb_tag, 6'd31);
                chk("flush wb data", bus.wb_data, 32'h600DF00D);
                wbn++;
            end
            @(negedge clk);
        end
        bus.mem_resp_valid = 1'b0;
        chk("flush new req seen", seen, 1);
        chk("flush wb count", wbn, 1);
    endtask

    task automatic seq_flush_req_and_reset();
        int wbn = 0;
        @(negedge clk);
        drive(1'b0, 3'b010, 32'hC000, 32'h0, 32'h0, 6'd51);
        bus.mem_req_ready = 1'b0;
        bus.in_valid      = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("flreq req valid", bus.mem_req_valid, 1);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        chk("flreq withdrawn", bus.mem_req_valid, 0);
        for (int t = 0; t < 6; t++) begin
            if (bus.wb_valid || bus.mem_req_valid) wbn++;
            @(negedge clk);
        end
        chk("flreq quiet after flush", wbn, 0);
        drive(1'b0, 3'b010, 32'hD000, 32'h0, 32'h0, 6'd52);
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst mid req valid", bus.mem_req_valid, 1);
        #2 rst = 1'b1;
        #1;
        chk("rst mid req dropped", bus.mem_req_valid, 0);
        chk("rst mid in_ready", bus.in_ready, 1);
        chk("rst mid wb_valid", bus.wb_valid, 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0]  = '{1'b0, 3'b010, 32'h1000, 32'h4, 32'h0, 6'd5,  32'hDEADBEEF, 32'h1004, 4'h0, 32'h0, 32'hDEADBEEF, 1'b0, 4};
        vecs[1]  = '{1'b0, 3'b000, 32'h2000, 32'h3, 32'h0, 6'd6,  32'h80FFFF12, 32'h2000, 4'h0, 32'h0, 32'hFFFFFF80, 1'b0, 4};
        vecs[2]  = '{1'b0, 3'b100, 32'h2000, 32'h3, 32'h0, 6'd7,  32'h80FFFF12, 32'h2000, 4'h0, 32'h0, 32'h00000080, 1'b0, 4};
        vecs[3]  = '{1'b0, 3'b101, 32'h2000, 32'h2, 32'h0, 6'd8,  32'h80FFFF12, 32'h2000, 4'h0, 32'h0, 32'h000080FF, 1'b0, 4};
        vecs[4]  = '{1'b0, 3'b001, 32'h2000, 32'h2, 32'h0, 6'd9,  32'h80FFFF12, 32'h2000, 4'h0, 32'h0, 32'hFFFF80FF, 1'b0, 4};
        vecs[5]  = '{1'b0, 3'b010, 32'hFFFFFFFC, 32'h8, 32'h0, 6'd12, 32'h11223344, 32'h0004, 4'h0, 32'h0, 32'h11223344, 1'b0, 4};
        vecs[6]  = '{1'b0, 3'b010, 32'h3000, 32'hFFFFFFFC, 32'h0, 6'd13, 32'h0BADCAFE, 32'h2FFC, 4'h0, 32'h0, 32'h0BADCAFE, 1'b0, 4};
        vecs[7]  = '{1'b1, 3'b000, 32'h5000, 32'h1, 32'h123456AB, 6'd14, 32'h0, 32'h5000, 4'b0010, 32'h3456AB00, 32'h0, 1'b0, 3};
        vecs[8]  = '{1'b1, 3'b000, 32'h5000, 32'h3, 32'h000000AB, 6'd15, 32'h0, 32'h5000, 4'b1000, 32'hAB000000, 32'h0, 1'b0, 3};
        vecs[9]  = '{1'b1, 3'b010, 32'h6000, 32'h0, 32'hCAFEF00D, 6'd16, 32'h0, 32'h6000, 4'b1111, 32'hCAFEF00D, 32'h0, 1'b0, 3};
        vecs[10] = '{1'b0, 3'b001, 32'h7000, 32'h1, 32'h0, 6'd17, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 1'b1, 2};
        vecs[11] = '{1'b0, 3'b111, 32'h7000, 32'h0, 32'h0, 6'd18, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 1'b1, 2};
        vecs[12] = '{1'b1, 3'b010, 32'h8000, 32'h2, 32'h55, 6'd19, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 1'b1, 2};
        vecs[13] = '{1'b0, 3'b000, 32'h2000, 32'h1, 32'h0, 6'd20, 32'h00007F00, 32'h2000, 4'h0, 32'h0, 32'h0000007F, 1'b0, 4};

        bus.flush          = 1'b0;
        bus.in_valid       = 1'b0;
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_rdata = 32'h0;
        drive(1'b0, 3'b000, 32'h0, 32'h0, 32'h0, '0);
        repeat (2) @(negedge clk);
        chk("reset in_ready", bus.in_ready, 1);
        chk("reset req_valid", bus.mem_req_valid, 0);
        chk("reset req_we", bus.mem_req_we, 0);
        chk("reset req_addr", bus.mem_req_addr, 32'h0);
        chk("reset req_wstrb", bus.mem_req_wstrb, 4'h0);
        chk("reset wb_valid", bus.wb_valid, 0);
        chk("reset wb_tag", bus.wb_tag, 6'd0);
        chk("reset wb_data", bus.wb_data, 32'h0);
        chk("reset wb_exc", bus.wb_exc, 0);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) run_vec(i);
        seq_store_stall();
        seq_exceptions();
        seq_queue_full();
        seq_flush_wait();
        seq_flush_req_and_reset();
        run_vec(0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
